byte_serial_adder: RTL and testbench

BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

---
 rtl/byte_serial_adder.sv | 129 ++++++++++++
 tb/tb_byte_serial_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_adder.sv
// Byte-serial adder: adds two NBYTES-byte operands one byte pair per cycle,
// least significant byte first, with valid/ready handshakes on both sides.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CI,
  input  logic [7:0] A_IN,
  input  logic [7:0] B_IN,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [7:0] SUM_OUT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_LAST,
  output logic       CO,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [7:0]    sum_q, sum_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          co_q, co_d;
  logic          done_q, done_d;

  logic       in_ready;
  logic       accept;
  logic       consume;
  logic [8:0] add_res;

  // The single output register may be refilled in the same cycle it is drained.
  assign in_ready = (state_q == RUN) && (!out_valid_q || OUT_READY);
  assign accept   = IN_VALID && in_ready;
  assign consume  = out_valid_q && OUT_READY;
  assign add_res  = {1'b0, A_IN} + {1'b0, B_IN} + {8'd0, carry_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    co_d        = co_q;
    done_d      = 1'b0;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          carry_d = CI;
          cnt_d   = '0;
          co_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          sum_d       = add_res[7:0];
          carry_d     = add_res[8];
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == LAST_IDX);
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            co_d    = add_res[8];
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Only the final byte can still be pending here.
        if (consume) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      co_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      co_q        <= co_d;
      done_q      <= done_d;
    end
  end

  assign IN_READY  = in_ready;
  assign SUM_OUT   = sum_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign CO        = co_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Bench for byte_serial_adder: a 4-byte instance and a 1-byte instance checked
// against whole-operand arithmetic computed inside the bench.
module tb_byte_serial_adder;

  logic       CLK;
  logic       RST;

  logic       START, CI, IN_VALID, OUT_READY;
  logic [7:0] A_IN, B_IN;
  logic       IN_READY, OUT_VALID, OUT_LAST, CO, BUSY, DONE;
  logic [7:0] SUM_OUT;

  logic       s_START, s_CI, s_IN_VALID, s_OUT_READY;
  logic [7:0] s_A_IN, s_B_IN;
  logic       s_IN_READY, s_OUT_VALID, s_OUT_LAST, s_CO, s_BUSY, s_DONE;
  logic [7:0] s_SUM_OUT;

  int vectors = 0;
  int miscompares = 0;

  byte_serial_adder #(.NBYTES(4)) dut4 (
    .CLK(CLK), .RST(RST), .START(START), .CI(CI),
    .A_IN(A_IN), .B_IN(B_IN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SUM_OUT(SUM_OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_LAST(OUT_LAST), .CO(CO), .BUSY(BUSY), .DONE(DONE)
  );

  byte_serial_adder #(.NBYTES(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(s_START), .CI(s_CI),
    .A_IN(s_A_IN), .B_IN(s_B_IN), .IN_VALID(s_IN_VALID), .IN_READY(s_IN_READY),
    .SUM_OUT(s_SUM_OUT), .OUT_VALID(s_OUT_VALID), .OUT_READY(s_OUT_READY),
    .OUT_LAST(s_OUT_LAST), .CO(s_CO), .BUSY(s_BUSY), .DONE(s_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 4-byte operation. mode 0: always ready, 1: consumer stalls three
  // cycles after the first byte, 2: random valid/ready, 3: START pulse mid-run.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input int mode);
    logic [32:0] ref_sum;
    logic [7:0]  held_sum;
    logic        held_valid;
    logic        exp_valid;
    logic        exp_ready;
    int acc, cons, cyc;
    ref_sum    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    held_valid = 1'b0;
    held_sum   = 8'h00;
    acc  = 0;
    cons = 0;
    cyc  = 0;

    @(negedge CLK);
    START = 1'b1; CI = ci; IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0; CI = ~ci;
    #1;
    checkOutput("busy_after_start", 32'(BUSY), 32'd1);
    checkOutput("co_cleared", 32'(CO), 32'd0);

    while (cons < 4 && cyc < 300) begin
      if (mode == 2) begin
        IN_VALID  = ($urandom_range(3) != 0);
        OUT_READY = ($urandom_range(2) != 0);
      end else if (mode == 1) begin
        IN_VALID  = 1'b1;
        OUT_READY = !(cyc >= 2 && cyc <= 4);
      end else begin
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
      end
      START = (mode == 3 && cyc == 1);
      if (acc < 4) begin
        A_IN = a[8*acc +: 8];
        B_IN = b[8*acc +: 8];
      end else begin
        A_IN = 8'($urandom);
        B_IN = 8'($urandom);
      end
      #1;
      exp_valid = (acc > cons);
      exp_ready = (acc < 4) && (!exp_valid || OUT_READY);
      checkOutput("out_valid", 32'(OUT_VALID), 32'(exp_valid));
      checkOutput("in_ready", 32'(IN_READY), 32'(exp_ready));
      if (held_valid) checkOutput("held_sum", 32'(SUM_OUT), 32'(held_sum));
      if (OUT_VALID && OUT_READY) begin
        checkOutput("sum_byte", 32'(SUM_OUT), 32'(ref_sum[8*cons +: 8]));
        checkOutput("out_last", 32'(OUT_LAST), 32'(cons == 3));
        cons++;
      end
      held_valid = OUT_VALID && !OUT_READY;
      held_sum   = SUM_OUT;
      if (IN_VALID && IN_READY) acc++;
      cyc++;
      @(negedge CLK);
    end
    START = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    checkOutput("bytes_timeout", 32'(cons), 32'd4);
    #1;
    checkOutput("done_pulse", 32'(DONE), 32'd1);
    checkOutput("busy_idle", 32'(BUSY), 32'd0);
    checkOutput("out_valid_idle", 32'(OUT_VALID), 32'd0);
    checkOutput("carry_out", 32'(CO), 32'(ref_sum[32]));
    @(negedge CLK);
    #1;
    checkOutput("done_single", 32'(DONE), 32'd0);
    checkOutput("carry_out_hold", 32'(CO), 32'(ref_sum[32]));
  endtask

  // Abandons a 4-byte operation with RST after two bytes have been accepted.
  task automatic applyResetMidOp(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge CLK);
    START = 1'b1; CI = ci; IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1;
      A_IN = a[8*i +: 8];
      B_IN = b[8*i +: 8];
      @(negedge CLK);
    end
    OUT_READY = 1'b0;
    #1;
    checkOutput("pre_reset_valid", 32'(OUT_VALID), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("rst_sum", 32'(SUM_OUT), 32'd0);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_out_last", 32'(OUT_LAST), 32'd0);
    checkOutput("rst_co", 32'(CO), 32'd0);
    checkOutput("rst_done", 32'(DONE), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      checkOutput("post_rst_done", 32'(DONE), 32'd0);
      checkOutput("post_rst_busy", 32'(BUSY), 32'd0);
    end
  endtask

  // One operation on the single-byte instance.
  task automatic applySingle(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    @(negedge CLK);
    s_START = 1'b1; s_CI = ci; s_IN_VALID = 1'b0; s_OUT_READY = 1'b1;
    @(negedge CLK);
    s_START = 1'b0; s_IN_VALID = 1'b1; s_A_IN = a; s_B_IN = b;
    #1;
    checkOutput("s_in_ready", 32'(s_IN_READY), 32'd1);
    @(negedge CLK);
    s_IN_VALID = 1'b0;
    #1;
    checkOutput("s_out_valid", 32'(s_OUT_VALID), 32'd1);
    checkOutput("s_sum", 32'(s_SUM_OUT), 32'(ref_sum[7:0]));
    checkOutput("s_out_last", 32'(s_OUT_LAST), 32'd1);
    checkOutput("s_co", 32'(s_CO), 32'(ref_sum[8]));
    checkOutput("s_in_ready_drain", 32'(s_IN_READY), 32'd0);
    @(negedge CLK);
    #1;
    checkOutput("s_done", 32'(s_DONE), 32'd1);
    checkOutput("s_busy", 32'(s_BUSY), 32'd0);
    checkOutput("s_co_hold", 32'(s_CO), 32'(ref_sum[8]));
    @(negedge CLK);
    #1;
    checkOutput("s_done_single", 32'(s_DONE), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0; CI = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1; A_IN = 8'h00; B_IN = 8'h00;
    s_START = 1'b0; s_CI = 1'b0; s_IN_VALID = 1'b0; s_OUT_READY = 1'b1; s_A_IN = 8'h00; s_B_IN = 8'h00;
    #2;
    checkOutput("reset_sum", 32'(SUM_OUT), 32'd0);
    checkOutput("reset_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_in_ready", 32'(IN_READY), 32'd0);
    checkOutput("reset_done", 32'(DONE), 32'd0);
    checkOutput("reset_co", 32'(CO), 32'd0);
    checkOutput("s_reset_out_valid", 32'(s_OUT_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1, 0);
    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, 0);
    applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1, 1);
    applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1, 3);
    applyResetMidOp(32'h000000FF, 32'h00000001, 1'b0);
    applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1, 0);

    $display("[TB] single-byte instance");
    applySingle(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applySingle(8'($urandom), 8'($urandom), 1'($urandom_range(1)));
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(1)), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
